// File: rtl/rng_arbiter.sv
// Round-robin arbiter granting one RNG transaction at a time to up to NREQ requesters.
// Optional WAIT watchdog enabled by defining RNG_ARB_TIMEOUT_EN.
module rng_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned DW      = 96,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_in_mod,
   input  logic [NREQ*DW-1:0] req_seed,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      rdata,
   output logic               busy,
   output logic               err,
   output logic               rng_start,
   output logic [DW-1:0]      rng_seed,
   output logic               rng_in_mod,
   input  logic [DW-1:0]      rng_data,
   input  logic               rng_finish
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("rng_arbiter: NREQ must be in 2..8");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("rng_arbiter: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [DW-1:0]   rng_seed_q, rng_seed_d;
   logic            rng_start_q, rng_start_d;
   logic            rng_in_mod_q, rng_in_mod_d;
   logic            err_q, err_d;
   logic            busy_q;
   logic            timeout_hit;

   logic            req_any;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;
   int unsigned     pos;

   // First requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      req_any = 1'b0;
      pick    = rr_ptr_q;
      cand    = '0;
      pos     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos = 32'(rr_ptr_q) + k;
         if (pos >= NREQ) begin
            pos = pos - NREQ;
         end
         cand = IW'(pos);
         if (!req_any && req[cand]) begin
            req_any = 1'b1;
            pick    = cand;
         end
      end
   end

`ifdef RNG_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wd_cnt_q;

   // Cleared in ISSUE so the count starts from zero on the first WAIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
      end else if (state_q == StIssue) begin
         wd_cnt_q <= '0;
      end else if (state_q == StWait && !timeout_hit) begin
         wd_cnt_q <= wd_cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == StWait) && (wd_cnt_q == CW'(TIMEOUT));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_any) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (rng_finish || timeout_hit) begin
               state_d = StDeliver;
            end
         end
         StDeliver: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      idx_d        = idx_q;
      gnt_d        = gnt_q;
      done_d       = '0;
      rdata_d      = rdata_q;
      err_d        = 1'b0;
      rng_start_d  = 1'b0;
      rng_seed_d   = '0;
      rng_in_mod_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_any) begin
               idx_d        = pick;
               gnt_d        = {{(NREQ-1){1'b0}}, 1'b1} << pick;
               rng_start_d  = 1'b1;
               rng_seed_d   = req_seed[pick*DW +: DW];
               rng_in_mod_d = req_in_mod[pick];
            end
         end
         StWait: begin
            if (rng_finish || timeout_hit) begin
               if (rng_finish) begin
                  rdata_d = rng_data;
               end else begin
                  err_d = 1'b1;
               end
               // A requester that withdrew gets no done pulse.
               if (req[idx_q]) begin
                  done_d = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
               end
            end
         end
         StDeliver: begin
            gnt_d    = '0;
            rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         idx_q        <= '0;
         gnt_q        <= '0;
         done_q       <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         rng_start_q  <= 1'b0;
         rng_seed_q   <= '0;
         rng_in_mod_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         idx_q        <= idx_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         busy_q       <= (state_d != StIdle);
         rng_start_q  <= rng_start_d;
         rng_seed_q   <= rng_seed_d;
         rng_in_mod_q <= rng_in_mod_d;
      end
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign rng_start  = rng_start_q;
   assign rng_seed   = rng_seed_q;
   assign rng_in_mod = rng_in_mod_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: transaction-level reference model plus directed tests.
`timescale 1ns/1ps
module tb_rng_arbiter;

   localparam int unsigned NREQ    = 2;
   localparam int unsigned DW      = 96;
   localparam int unsigned TIMEOUT = 15;

   localparam logic [DW-1:0] SEED0  = 96'h0000_0000_0000_0000_FFFF_FFFF;
   localparam logic [DW-1:0] SEED1  = 96'h1111_2222_3333_4444_5555_6666;
   localparam logic [DW-1:0] DAT_A5 = {12{8'hA5}};

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_in_mod;
   logic [NREQ*DW-1:0] req_seed;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [DW-1:0]      rdata;
   logic               busy;
   logic               err;
   logic               rng_start;
   logic [DW-1:0]      rng_seed;
   logic               rng_in_mod;
   logic [DW-1:0]      rng_data;
   logic               rng_finish;

   rng_arbiter #(
      .NREQ    (NREQ),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_in_mod (req_in_mod),
      .req_seed   (req_seed),
      .gnt        (gnt),
      .done       (done),
      .rdata      (rdata),
      .busy       (busy),
      .err        (err),
      .rng_start  (rng_start),
      .rng_seed   (rng_seed),
      .rng_in_mod (rng_in_mod),
      .rng_data   (rng_data),
      .rng_finish (rng_finish)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_starts = 0;
   bit cmp_en  = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: owner of the RNG, cycles since grant, and the round-robin pointer.
   int              m_owner;
   int              m_phase;   // 1 = start cycle, 2 = awaiting RNG, 3 = delivering
   int              m_wait;
   int              m_ptr;
   logic [NREQ-1:0] m_done;
   logic            m_err;
   logic            m_start;
   logic [DW-1:0]   m_seed;
   logic            m_mod;
   logic [DW-1:0]   m_rdata;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1; m_phase = 0; m_wait = 0; m_ptr = 0;
         m_done = '0; m_err = 1'b0; m_start = 1'b0; m_seed = '0; m_mod = 1'b0; m_rdata = '0;
      end else begin
         m_done = '0; m_err = 1'b0; m_start = 1'b0; m_seed = '0; m_mod = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (m_ptr + k) % NREQ;
               if (m_owner < 0 && req[j]) begin
                  m_owner = j;
                  m_phase = 1;
                  m_start = 1'b1;
                  m_seed  = req_seed[j*DW +: DW];
                  m_mod   = req_in_mod[j];
               end
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
            m_wait  = 0;
         end else if (m_phase == 2) begin
            if (rng_finish) begin
               m_rdata         = rng_data;
               m_done[m_owner] = req[m_owner];
               m_phase         = 3;
`ifdef RNG_ARB_TIMEOUT_EN
            end else if (m_wait == TIMEOUT) begin
               m_err           = 1'b1;
               m_done[m_owner] = req[m_owner];
               m_phase         = 3;
`endif
            end else begin
               m_wait++;
            end
         end else begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rng_start) n_starts++;
      if (cmp_en) begin
         logic [NREQ-1:0] eg;
         eg = '0;
         if (m_owner >= 0) eg[m_owner] = 1'b1;
         check("gnt", gnt, eg);
         check("done", done, m_done);
         check("rdata", rdata, m_rdata);
         check("busy", busy, m_owner >= 0);
         check("err", err, m_err);
         check("rng_start", rng_start, m_start);
         check("rng_seed", rng_seed, m_seed);
         check("rng_in_mod", rng_in_mod, m_mod);
      end
   end

   task automatic wait_start();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (rng_start) ok = 1'b1;
         else @(negedge clk);
      end
      check("start_seen", ok, 1);
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (done != '0) ok = 1'b1;
         else @(negedge clk);
      end
      check("done_seen", ok, 1);
   endtask

   task automatic pulse_finish(input logic [DW-1:0] d);
      rng_finish = 1'b1;
      rng_data   = d;
      @(negedge clk);
      rng_finish = 1'b0;
      rng_data   = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int gap;
      logic [DW-1:0] d;
      rst = 1'b1; req = '0; req_in_mod = 2'b01; req_seed = {SEED1, SEED0};
      rng_data = '0; rng_finish = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata", rdata, 0);
      check("rst_start", rng_start, 0);
      check("rst_seed", rng_seed, 0);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Single request from requester 0
      s0 = n_starts;
      req = 2'b01;
      wait_start();
      check("t1_seed", rng_seed, SEED0);
      check("t1_mod", rng_in_mod, 1);
      check("t1_gnt", gnt, 2'b01);
      repeat (3) @(negedge clk);
      pulse_finish(DAT_A5);
      wait_done();
      check("t1_done", done, 2'b01);
      check("t1_rdata", rdata, DAT_A5);
      req = '0;
      @(negedge clk);
      check("t1_busy1", busy, 0);
      @(negedge clk);
      check("t1_busy2", busy, 0);
      check("t1_nstarts", n_starts - s0, 1);

      // Fairness with both requesters held
      do_reset();
      req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_start();
         check("fair_gnt", gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
         check("fair_seed", rng_seed, (t % 2 == 0) ? SEED0 : SEED1);
         check("fair_mod", rng_in_mod, (t % 2 == 0) ? 1 : 0);
         repeat (2) @(negedge clk);
         d = 96'hC0DE_0000_0000_0000_0000_0000 + DW'(t);
         pulse_finish(d);
         wait_done();
         check("fair_done", done, (t % 2 == 0) ? 2'b01 : 2'b10);
         check("fair_rdata", rdata, d);
         if (t == 3) begin
            req = '0;
         end else begin
            gap = 0;
            do begin
               @(negedge clk);
               gap++;
            end while (gnt == '0 && gap < 10);
            check("fair_gap", gap, 2);
         end
      end
      repeat (2) @(negedge clk);

      // Stray finishes in IDLE and in the start cycle
      pulse_finish(96'hBAD1);
      check("stray_idle_done", done, 0);
      check("stray_idle_rdata", rdata, 96'hC0DE_0000_0000_0000_0000_0003);
      check("stray_idle_busy", busy, 0);
      req = 2'b01;
      wait_start();
      pulse_finish(96'hBAD2);
      repeat (3) begin
         check("stray_issue_done", done, 0);
         check("stray_issue_busy", busy, 1);
         @(negedge clk);
      end
      pulse_finish(96'h1234_5678_9ABC_DEF0_0F1E_2D3C);
      wait_done();
      check("stray_done", done, 2'b01);
      check("stray_rdata", rdata, 96'h1234_5678_9ABC_DEF0_0F1E_2D3C);
      req = '0;
      repeat (2) @(negedge clk);

      // Requester 1 withdraws while waiting on the RNG
      req = 2'b10;
      wait_start();
      check("drop_gnt", gnt, 2'b10);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      pulse_finish(96'hCCCC_0000_0000_0000_0000_0001);
      check("drop_done", done, 0);
      check("drop_busy", busy, 1);
      check("drop_rdata", rdata, 96'hCCCC_0000_0000_0000_0000_0001);
      @(negedge clk);
      req = 2'b11;
      wait_start();
      check("drop_ptr_gnt", gnt, 2'b01);
      @(negedge clk);
      pulse_finish(96'h77);
      wait_done();
      check("drop_next_done", done, 2'b01);
      req = '0;
      repeat (2) @(negedge clk);

      // Reset while waiting on the RNG
      req = 2'b01;
      wait_start();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rstw_gnt", gnt, 0);
      check("rstw_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      pulse_finish(96'hEEEE);
      check("rstw_done", done, 0);
      check("rstw_rdata", rdata, 0);
      @(negedge clk);
      check("rstw_busy2", busy, 0);

`ifdef RNG_ARB_TIMEOUT_EN
      // RNG never answers: watchdog delivers with err
      req = 2'b11;
      wait_start();
      repeat (16) @(negedge clk);
      check("to_early_done", done, 0);
      @(negedge clk);
      check("to_done", done, 2'b01);
      check("to_err", err, 1);
      repeat (2) @(negedge clk);
      check("to_next_gnt", gnt, 2'b10);
      req = '0;
      do_reset();
`else
      // RNG never answers: arbiter keeps waiting
      req = 2'b01;
      wait_start();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         check("nto_state", {busy, err, done}, 4'b1000);
      end
      req = '0;
      do_reset();
`endif
      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares the single 96-bit RNG core between up to NREQ requesters, for example K-generation (error-space sampling) and c-generation. Each requester presents a seed and mode.
- Round-robin selection; the winning requester is granted one RNG transaction.
- The arbiter drives the RNG start/seed/mode pins, waits for rng_finish, and returns the registered random word with a one-cycle done pulse to the winner.
- Sits between the keygen/encrypt controllers and the RNG core.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DW, 96, RNG data and seed width
- TIMEOUT, 1023, watchdog limit in cycles for WAIT (used only with RNG_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level; held until own done pulse
- req_in_mod  in  NREQ  per-requester seed-load mode bit
- req_seed  in  NREQ*DW  per-requester seed; slice i = [i*DW +: DW]
- gnt  out  NREQ  one-hot grant; held for the whole transaction
- done  out  NREQ  one-hot, one-cycle pulse when rdata is valid for that requester
- rdata  out  DW  registered random word, broadcast to all requesters
- busy  out  1  high in any state other than IDLE
- err  out  1  timeout pulse, coincident with done (0 when the macro is off)
- rng_start  out  1  one-cycle start pulse to the RNG
- rng_seed  out  DW  seed to the RNG, valid while rng_start=1
- rng_in_mod  out  1  mode to the RNG, valid while rng_start=1
- rng_data  in  DW  RNG output word
- rng_finish  in  1  RNG completion pulse

Behaviour:
- Async reset values:
  - state=IDLE, rr_ptr=0
  - gnt, done, rdata, busy, err, rng_start, rng_seed, rng_in_mod all 0
  - watchdog counter 0
- FSM, all outputs registered:
  - IDLE:
    - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap modulo NREQ.
    - Latch its index, set gnt[idx]=1, and go to ISSUE.
    - Drive rng_start=1, rng_seed=req_seed slice, rng_in_mod=req_in_mod[idx] for exactly the ISSUE cycle.
  - ISSUE: drop rng_start, rng_seed and rng_in_mod to 0; go to WAIT unconditionally.
  - WAIT:
    - On rng_finish: rdata<=rng_data, go to DELIVER, raise done[idx] in the same registered update so it is visible in DELIVER.
    - Otherwise stay in WAIT.
  - DELIVER:
    - done[idx] is high for this single cycle.
    - On exit: gnt<=0, done<=0, rr_ptr<=(idx+1) mod NREQ, return to IDLE.
- Latency: req seen in IDLE at cycle t -> gnt and rng_start at t+1 -> WAIT at t+2 -> rng_finish at cycle f -> done/rdata at f+1 -> IDLE at f+2.
- Minimum service gap between back-to-back grants: 2 cycles after done.
- rdata holds its value until the next DELIVER. It is not cleared on return to IDLE.
- rng_finish outside WAIT (IDLE, ISSUE, DELIVER) is ignored: no state change, rdata unchanged.
- Requester drops req mid-transaction:
  - The transaction still completes on the RNG.
  - done is suppressed if req[idx]=0 when entering DELIVER; rdata is still updated.
  - The pointer still advances.
- Requests changing while gnt is held have no effect on the current transaction.
- Seed and mode are sampled only in the IDLE->ISSUE cycle.
- Reset asserted mid-transaction: immediate return to reset values. The RNG is not notified, and a subsequent stray rng_finish is ignored per the rule above.
- Only one transaction is outstanding at a time; gnt is always one-hot or zero.

Optional Feature:
- Macro RNG_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments every WAIT cycle and clears on entry to WAIT.
  - If it reaches TIMEOUT without rng_finish, go to DELIVER with done[idx]=1 and err=1 for that cycle, rdata unchanged, pointer advances.
  - A later stray rng_finish is ignored.
- Undefined: no counter logic; err is tied to 0; WAIT waits indefinitely.

Test Plan:
- Single request:
  - Stimulus: req=01, seed0=96'hFFFFFFFF, in_mod=1; RNG returns 96'hA5..A5 three cycles after start.
  - Required: rng_start pulses once with that seed and mode=1; done=01 one cycle with rdata=A5..A5; busy low two cycles after done.
- Fairness:
  - Stimulus: req=11 held continuously, RNG latency 2 cycles.
  - Required: grants alternate 01,10,01,10; each done is followed by the other requester's gnt 2 cycles later.
- Stray finish:
  - Stimulus: rng_finish pulse while IDLE, and again during ISSUE.
  - Required: no done, rdata unchanged, FSM still needs a WAIT-state finish.
- Drop and reset:
  - Stimulus: req[1] dropped during WAIT.
  - Required: done stays 00, rdata updated, rr_ptr=0.
  - Stimulus: separately, rst pulsed during WAIT.
  - Required: gnt=00 and busy=0 immediately, then a later rng_finish is ignored.
- Timeout (RNG_ARB_TIMEOUT_EN defined, TIMEOUT=15):
  - Stimulus: RNG never finishes.
  - Required: done and err pulse together 16 cycles after WAIT entry; next requester granted.
- Timeout disabled (macro undefined, same stimulus):
  - Required: arbiter remains in WAIT for 1000 cycles, err stays 0.
